// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file.
//   DEF_DW / DEF_PW / DEF_NR : default data width, pointer width, read-port count
//   word_t                   : one data word of the default width
//   addr_t                   : one register address of the default pointer width
package rf_pkg;
    localparam int DEF_DW = 8;
    localparam int DEF_PW = 3;
    localparam int DEF_NR = 3;

    typedef logic [DEF_DW-1:0] word_t;
    typedef logic [DEF_PW-1:0] addr_t;
endpackage

// File: rtl/rf_read_port.sv
// Single combinational read port of the register file.
// It selects the stored word and busy bit for rd_addr. It can optionally forward
// same-cycle write data and hide the busy bit cleared by a same-cycle load return.
// Register 0 can optionally be forced to read as zero and never busy.
// Ports:
//   rd_addr                      in  : register to read
//   regs_flat                    in  : all stored words, register i at [i*DW +: DW]
//   busy_vec                     in  : stored busy bits
//   wa_en/wa_addr/wa_data        in  : write port A of this cycle (bypass source)
//   wb_en/wb_addr/wb_data        in  : write port B of this cycle (bypass source)
//   busy_set_en/busy_set_addr    in  : busy set of this cycle
//   rd_data / rd_busy            out : read result
module rf_read_port import rf_pkg::*; #(
    parameter int DW      = DEF_DW,
    parameter int PW      = DEF_PW,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic [PW-1:0]           rd_addr,
    input  logic [(2**PW)*DW-1:0]   regs_flat,
    input  logic [(2**PW)-1:0]      busy_vec,
    input  logic                    wa_en,
    input  logic [PW-1:0]           wa_addr,
    input  logic [DW-1:0]           wa_data,
    input  logic                    wb_en,
    input  logic [PW-1:0]           wb_addr,
    input  logic [DW-1:0]           wb_data,
    input  logic                    busy_set_en,
    input  logic [PW-1:0]           busy_set_addr,
    output logic [DW-1:0]           rd_data,
    output logic                    rd_busy
);
    logic wa_hit, wb_hit, set_hit, is_zero;

    always_comb begin
        wa_hit  = wa_en && (wa_addr == rd_addr);
        wb_hit  = wb_en && (wb_addr == rd_addr);
        set_hit = busy_set_en && (busy_set_addr == rd_addr);
        is_zero = (ZERO_R0 != 0) && (rd_addr == '0);

        rd_data = regs_flat[int'(rd_addr)*DW +: DW];
        rd_busy = busy_vec[rd_addr];

        if (BYPASS != 0) begin
            // Port A has priority, matching the write-collision rule.
            if (wa_hit)      rd_data = wa_data;
            else if (wb_hit) rd_data = wb_data;
            // A returning load clears busy unless a new load is issued to the same register.
            if (wb_hit && !set_hit) rd_busy = 1'b0;
        end

        if (is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end
endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with a per-register load scoreboard.
// It has two write ports: A for ALU writeback and B for load return; A wins a collision.
// It has NR combinational read ports with optional same-cycle bypass.
// There is an optional hard-wired zero register.
// A sticky WAW flag is raised when port A writes a register still awaiting a load.
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   wa_en/wa_addr/wa_data               : write port A
//   wb_en/wb_addr/wb_data               : write port B, also clears busy of wb_addr
//   busy_set_en/busy_set_addr           : mark a register as awaiting a load
//   rd_addr  (NR*PW) / rd_data (NR*DW)  : packed read ports, port i at slice i
//   rd_busy  (NR)                       : busy flag per read port
//   waw_err                             : sticky write-after-write error
module reg_file_mp import rf_pkg::*; #(
    parameter int DW      = DEF_DW,
    parameter int PW      = DEF_PW,
    parameter int NR      = DEF_NR,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wa_en,
    input  logic [PW-1:0]     wa_addr,
    input  logic [DW-1:0]     wa_data,
    input  logic              wb_en,
    input  logic [PW-1:0]     wb_addr,
    input  logic [DW-1:0]     wb_data,
    input  logic              busy_set_en,
    input  logic [PW-1:0]     busy_set_addr,
    input  logic [NR*PW-1:0]  rd_addr,
    output logic [NR*DW-1:0]  rd_data,
    output logic [NR-1:0]     rd_busy,
    output logic              waw_err
);
    localparam int DEPTH = 2**PW;

    logic [DW-1:0]       regs_q [DEPTH];
    logic [DW-1:0]       regs_d [DEPTH];
    logic [DEPTH-1:0]    busy_q, busy_d;
    logic                waw_q, waw_d;
    logic [DEPTH*DW-1:0] regs_flat;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        waw_d  = waw_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!((ZERO_R0 != 0) && (i == 0))) begin
                if (wb_en && (wb_addr == PW'(i))) begin
                    regs_d[i] = wb_data;
                    busy_d[i] = 1'b0;
                end
                // Applied after B so that A wins data; set after clear so a new load wins.
                if (wa_en && (wa_addr == PW'(i)))             regs_d[i] = wa_data;
                if (busy_set_en && (busy_set_addr == PW'(i))) busy_d[i] = 1'b1;
            end
        end
        // busy_q[0] can never be set when register 0 is hard-wired, so no extra guard.
        if (wa_en && busy_q[wa_addr]) waw_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q <= '0;
            waw_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            waw_q  <= waw_d;
        end
    end

    assign waw_err = waw_q;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_flat
            assign regs_flat[g*DW +: DW] = regs_q[g];
        end
        // Bypass sources are masked in reset so every read port shows 0 while rst_n is low.
        for (g = 0; g < NR; g++) begin : g_rd
            rf_read_port #(
                .DW(DW), .PW(PW), .BYPASS(BYPASS), .ZERO_R0(ZERO_R0)
            ) u_port (
                .rd_addr       (rd_addr[g*PW +: PW]),
                .regs_flat     (regs_flat),
                .busy_vec      (busy_q),
                .wa_en         (wa_en & rst_n),
                .wa_addr       (wa_addr),
                .wa_data       (wa_data),
                .wb_en         (wb_en & rst_n),
                .wb_addr       (wb_addr),
                .wb_data       (wb_data),
                .busy_set_en   (busy_set_en & rst_n),
                .busy_set_addr (busy_set_addr),
                .rd_data       (rd_data[g*DW +: DW]),
                .rd_busy       (rd_busy[g])
            );
        end
    endgenerate
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. Three instances share one stimulus stream:
// u0 is the default (bypass on), u1 has BYPASS=0, and u2 has ZERO_R0=1.
module tb_reg_file_mp;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wa_en, wb_en, busy_set_en;
    logic [2:0]  wa_addr, wb_addr, busy_set_addr;
    word_t       wa_data, wb_data;
    logic [8:0]  rd_addr;
    logic [23:0] rd_data0, rd_data1, rd_data2;
    logic [2:0]  rd_busy0, rd_busy1, rd_busy2;
    logic        waw0, waw1, waw2;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1), .ZERO_R0(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0), .waw_err(waw0));

    reg_file_mp #(.BYPASS(0), .ZERO_R0(0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1), .waw_err(waw1));

    reg_file_mp #(.BYPASS(1), .ZERO_R0(1)) u2 (
        .clk(clk), .rst_n(rst_n),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .rd_addr(rd_addr), .rd_data(rd_data2), .rd_busy(rd_busy2), .waw_err(waw2));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wa_en = 1'b0; wb_en = 1'b0; busy_set_en = 1'b0;
    endtask

    task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
        rd_addr = {a2, a1, a0};
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        wa_addr = '0; wb_addr = '0; busy_set_addr = '0;
        wa_data = '0; wb_data = '0;
        set_rd(3'd1, 3'd2, 3'd3);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("reset_rd0", rd_data0, 24'h0);
        chk("reset_busy", {13'h0, rd_busy0}, 16'h0);
        chk("reset_waw", {15'h0, waw0}, 16'h0);

        // r1 <- AA and marked busy, then an async reset between edges.
        wa_en = 1'b1; wa_addr = 3'd1; wa_data = 8'hAA;
        busy_set_en = 1'b1; busy_set_addr = 3'd1;
        step(); idle(); #1;
        chk("r1_written", {8'h0, rd_data0[7:0]}, 16'hAA);
        chk("r1_busy", {15'h0, rd_busy0[0]}, 16'h1);
        rst_n = 1'b0; #1;
        chk("rst_mid_data", {8'h0, rd_data0[7:0]}, 16'h0);
        chk("rst_mid_busy", {15'h0, rd_busy0[0]}, 16'h0);
        chk("rst_mid_waw", {15'h0, waw0}, 16'h0);
        rst_n = 1'b1;

        // Bypass of port A: r2 <- 5C.
        set_rd(3'd2, 3'd3, 3'd6);
        wa_en = 1'b1; wa_addr = 3'd2; wa_data = 8'h5C; #1;
        chk("bypA_on", {8'h0, rd_data0[7:0]}, 16'h5C);
        chk("bypA_off_old", {8'h0, rd_data1[7:0]}, 16'h0);
        step(); idle(); #1;
        chk("bypA_off_after", {8'h0, rd_data1[7:0]}, 16'h5C);
        chk("bypA_on_after", {8'h0, rd_data0[7:0]}, 16'h5C);

        // Collision on r3: A=11 wins over B=22; plus B-only bypass on r6.
        wa_en = 1'b1; wa_addr = 3'd3; wa_data = 8'h11;
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'h22; #1;
        chk("coll_byp", {8'h0, rd_data0[15:8]}, 16'h11);
        chk("coll_nobyp", {8'h0, rd_data1[15:8]}, 16'h0);
        step(); idle(); #1;
        chk("coll_stored_u0", {8'h0, rd_data0[15:8]}, 16'h11);
        chk("coll_stored_u1", {8'h0, rd_data1[15:8]}, 16'h11);
        wb_en = 1'b1; wb_addr = 3'd6; wb_data = 8'h66; #1;
        chk("bypB_on", {8'h0, rd_data0[23:16]}, 16'h66);
        chk("bypB_off", {8'h0, rd_data1[23:16]}, 16'h0);
        step(); idle(); #1;
        chk("wb_stored", {8'h0, rd_data1[23:16]}, 16'h66);

        // Scoreboard on r4.
        set_rd(3'd4, 3'd5, 3'd0);
        busy_set_en = 1'b1; busy_set_addr = 3'd4; #1;
        chk("busy_before_edge", {15'h0, rd_busy0[0]}, 16'h0);
        step(); idle(); #1;
        chk("busy_set", {15'h0, rd_busy0[0]}, 16'h1);
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h7E; #1;
        chk("busy_clr_byp", {15'h0, rd_busy0[0]}, 16'h0);
        chk("busy_clr_nobyp", {15'h0, rd_busy1[0]}, 16'h1);
        chk("load_data_byp", {8'h0, rd_data0[7:0]}, 16'h7E);
        step(); idle(); #1;
        chk("load_stored", {8'h0, rd_data1[7:0]}, 16'h7E);
        chk("busy_cleared", {14'h0, rd_busy0[0], rd_busy1[0]}, 16'h0);
        busy_set_en = 1'b1; busy_set_addr = 3'd4;
        step(); idle();
        busy_set_en = 1'b1; busy_set_addr = 3'd4;
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h01;
        step(); idle(); #1;
        chk("set_beats_clr", {14'h0, rd_busy0[0], rd_busy1[0]}, 16'h3);

        // WAW on r5.
        busy_set_en = 1'b1; busy_set_addr = 3'd5;
        step(); idle(); #1;
        chk("waw_clear", {15'h0, waw0}, 16'h0);
        wa_en = 1'b1; wa_addr = 3'd5; wa_data = 8'h33;
        step(); idle(); #1;
        chk("waw_set", {13'h0, waw0, waw1, waw2}, 16'h7);
        chk("waw_data", {8'h0, rd_data0[15:8]}, 16'h33);
        chk("waw_busy_kept", {15'h0, rd_busy0[1]}, 16'h1);
        step(); #1;
        chk("waw_sticky", {15'h0, waw0}, 16'h1);
        rst_n = 1'b0; #1;
        chk("waw_rst", {15'h0, waw0}, 16'h0);
        rst_n = 1'b1;

        // Zero register: busy_set r0, then write r0 (u0 treats it as normal).
        set_rd(3'd4, 3'd5, 3'd0);
        busy_set_en = 1'b1; busy_set_addr = 3'd0;
        step(); idle(); #1;
        chk("r0_busy_u2", {15'h0, rd_busy2[2]}, 16'h0);
        chk("r0_busy_u0", {15'h0, rd_busy0[2]}, 16'h1);
        wa_en = 1'b1; wa_addr = 3'd0; wa_data = 8'hFF; #1;
        chk("r0_nobyp_u2", {8'h0, rd_data2[23:16]}, 16'h0);
        chk("r0_byp_u0", {8'h0, rd_data0[23:16]}, 16'hFF);
        step(); idle(); #1;
        chk("r0_data_u2", {8'h0, rd_data2[23:16]}, 16'h0);
        chk("r0_waw_u2", {15'h0, waw2}, 16'h0);
        chk("r0_waw_u0", {15'h0, waw0}, 16'h1);
        chk("r0_data_u0", {8'h0, rd_data0[23:16]}, 16'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
